// File: rtl/axi_mem_slave_model.sv
// AXI4 slave memory model: INCR bursts with wrap-around word addressing, programmable read
// latency, periodic ready/valid bubbles and SLVERR on out-of-range or WLAST-mismatched writes.
module axi_mem_slave_model #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2,
  parameter int STALL_EVERY  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RREADY,
  output logic                  RLAST,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  output logic                  err_wlast
);
  localparam int BB    = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {S_RIDLE, S_RWAIT, S_RBURST} rstate_t;
  typedef enum logic [1:0] {S_WIDLE, S_WDATA, S_WRESP} wstate_t;

  rstate_t                 rstate;
  wstate_t                 wstate;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   raddr, rnext, waddr;
  logic [DEPTH_LOG2-1:0]   ar_idx, aw_idx;
  logic                    ar_oor, aw_oor, r_oor, w_oor, w_err;
  logic [7:0]              rlen, rbeat, wlen, wbeat;
  logic [LW-1:0]           rlat;
  logic [15:0]             rcnt, wcnt;
  logic                    wr_en, w_last, w_mis;
  logic                    unused_ok;

  function automatic logic stall_due(input logic [15:0] n);
    return (STALL_EVERY > 0) && (n == 16'(STALL_EVERY));
  endfunction

  // Range is judged on the start address only; beats then wrap inside the array.
  assign ar_idx    = ARADDR[DEPTH_LOG2+BB-1:BB];
  assign aw_idx    = AWADDR[DEPTH_LOG2+BB-1:BB];
  assign ar_oor    = |(ARADDR >> (DEPTH_LOG2 + BB));
  assign aw_oor    = |(AWADDR >> (DEPTH_LOG2 + BB));
  assign rnext     = raddr + 1'b1;
  assign unused_ok = ^{ARSIZE, AWSIZE, ARADDR, AWADDR};

  assign wr_en  = (wstate == S_WDATA) && WVALID && WREADY && !w_oor;
  assign w_last = (wbeat == wlen);
  assign w_mis  = (WLAST != w_last);

  // Storage is never reset; a read fetch on the same edge sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= WDATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate  <= S_RIDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RDATA   <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rbeat   <= '0;
      r_oor   <= 1'b0;
      rlat    <= '0;
      rcnt    <= '0;
    end else begin
      case (rstate)
        S_RIDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            raddr   <= ar_idx;
            rlen    <= ARLEN;
            r_oor   <= ar_oor;
            rbeat   <= '0;
            rlat    <= '0;
            rcnt    <= '0;
            rstate  <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          rlat <= rlat + 1'b1;
          if (rlat == LW'(READ_LATENCY - 1)) begin
            RVALID <= 1'b1;
            RDATA  <= r_oor ? '0 : mem[raddr];
            RLAST  <= (rlen == 8'd0);
            rstate <= S_RBURST;
          end
        end
        S_RBURST: begin
          if (RVALID && RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              rstate  <= S_RIDLE;
            end else begin
              raddr <= rnext;
              rbeat <= rbeat + 8'd1;
              RDATA <= r_oor ? '0 : mem[rnext];
              RLAST <= (rbeat + 8'd1 == rlen);
              if (stall_due(rcnt + 16'd1)) begin
                RVALID <= 1'b0;
                rcnt   <= '0;
              end else begin
                rcnt <= rcnt + 16'd1;
              end
            end
          end else if (!RVALID) begin
            RVALID <= 1'b1;
          end
        end
        default: rstate <= S_RIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate    <= S_WIDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= 2'b00;
      err_wlast <= 1'b0;
      waddr     <= '0;
      wlen      <= '0;
      wbeat     <= '0;
      w_oor     <= 1'b0;
      w_err     <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (wstate)
        S_WIDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            waddr   <= aw_idx;
            wlen    <= AWLEN;
            w_oor   <= aw_oor;
            wbeat   <= '0;
            w_err   <= 1'b0;
            wcnt    <= '0;
            wstate  <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (WVALID && WREADY) begin
            if (w_mis) begin
              err_wlast <= 1'b1;
              w_err     <= 1'b1;
            end
            // Burst length comes from AWLEN; WLAST only feeds the error check.
            if (w_last) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP  <= (w_oor || w_err || w_mis) ? 2'b10 : 2'b00;
              wstate <= S_WRESP;
            end else begin
              waddr <= waddr + 1'b1;
              wbeat <= wbeat + 8'd1;
              if (stall_due(wcnt + 16'd1)) begin
                WREADY <= 1'b0;
                wcnt   <= '0;
              end else begin
                wcnt <= wcnt + 16'd1;
              end
            end
          end else if (!WREADY) begin
            WREADY <= 1'b1;
          end
        end
        S_WRESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            wstate  <= S_WIDLE;
          end
        end
        default: wstate <= S_WIDLE;
      endcase
    end
  end
endmodule
